// File: rtl/ps2_bridge_pkg.sv
// Shared types, constants and the nibble-to-ASCII helper for the PS/2 to UART bridge.
package ps2_bridge_pkg;

    typedef enum logic [1:0] {
        MODE_RAW      = 2'b00,
        MODE_HEX      = 2'b01,
        MODE_HEX_LINE = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // Uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

endpackage

// File: rtl/ps2_uart_bridge_if.sv
// Byte-in / character-out signals between the PS/2 receiver, the bridge and the uart TX port.
interface ps2_uart_bridge_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       tx;
    logic [7:0] tx_data;
    logic       tx_full;

    modport master (output in_valid, output in_data, output tx_full,
                    input  tx, input tx_data);
    modport slave  (input  in_valid, input in_data, input tx_full,
                    output tx, output tx_data);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data (valid the cycle after pop) and a level counter.
module sync_fifo #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            rdata_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q  <= rptr_q + 1'b1;
                rdata_q <= mem[rptr_q];
            end
            if (push && !pop) level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    assign rdata = rdata_q;
    assign level = level_q;
    assign full  = (level_q == DEPTH[AW:0]);
    assign empty = (level_q == '0);
endmodule

// File: rtl/ps2_uart_bridge.sv
// Buffers PS/2 scan codes and streams them to uart TX as raw bytes or ASCII hex,
// honouring tx_full and counting bytes dropped on a full FIFO.
module ps2_uart_bridge
    import ps2_bridge_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [7:0]  SEP        = 8'h20,
    parameter int unsigned OVF_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  clr_ovf,
    ps2_uart_bridge_if.slave      bus,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [OVF_W-1:0]      ovf_count,
    output logic                  busy
);
    state_t     state_q, state_d;
    mode_t      mode_q, mode_in;
    logic [7:0] byte_q, fifo_rdata, char_cur;
    logic [2:0] idx_q, n_chars;
    logic       fifo_full, fifo_empty, pop, push, drop;

    assign pop  = (state_q == IDLE) && en && !fifo_empty;
    assign push = bus.in_valid && en && (!fifo_full || pop);
    assign drop = bus.in_valid && en && fifo_full && !pop;

    sync_fifo #(.DW(8), .AW(DEPTH_LOG2)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        unique case (mode)
            2'b01:   mode_in = MODE_HEX;
            2'b10:   mode_in = MODE_HEX_LINE;
            default: mode_in = MODE_RAW;
        endcase
    end

    // Character at idx_q and character count for the latched byte/mode.
    always_comb begin
        char_cur = byte_q;
        n_chars  = 3'd1;
        case (mode_q)
            MODE_HEX: begin
                n_chars = 3'd3;
                case (idx_q)
                    3'd0:    char_cur = hex_ascii(byte_q[7:4]);
                    3'd1:    char_cur = hex_ascii(byte_q[3:0]);
                    default: char_cur = SEP;
                endcase
            end
            MODE_HEX_LINE: begin
                n_chars = 3'd4;
                case (idx_q)
                    3'd0:    char_cur = hex_ascii(byte_q[7:4]);
                    3'd1:    char_cur = hex_ascii(byte_q[3:0]);
                    3'd2:    char_cur = CHAR_CR;
                    default: char_cur = CHAR_LF;
                endcase
            end
            default: ;
        endcase
    end

    // tx is combinational from state so an asynchronous reset drops it immediately.
    assign bus.tx      = (state_q == EMIT) && !bus.tx_full;
    assign bus.tx_data = bus.tx ? char_cur : 8'h00;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop) state_d = LOAD;
            LOAD:    state_d = EMIT;
            EMIT:    if (!bus.tx_full) state_d = GAP;
            GAP:     state_d = (idx_q == n_chars) ? IDLE : EMIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_RAW;
            byte_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                byte_q <= fifo_rdata;
                mode_q <= mode_in;
                idx_q  <= '0;
            end else if (bus.tx) begin
                idx_q <= idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (clr_ovf) begin
            overflow  <= 1'b0;
            ovf_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (ovf_count != '1) ovf_count <= ovf_count + 1'b1;
        end
    end

    assign busy = (state_q != IDLE) || !fifo_empty;
endmodule
